mips_cpu_bus: RTL and testbench

//  Multicycle MIPS32 (little-endian) integer core with one Avalon-style memory bus.
//  - Instruction fetch and data access share that bus.
//  - Runs from the reset vector until it jumps to address 0, then halts.
//  - At halt it exposes register $v0 for checking.
//  - Sits at the top of the CPU hierarchy; a 32-bit RAM (bench: RAM_32x4096) is the only slave.

---
 rtl/mips_cpu_bus.sv | 161 ++++++++++++++++
 tb/tb_mips_cpu_bus.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_bus.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_cpu_bus : multicycle little-endian MIPS32 integer core, one Avalon bus |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module mips_cpu_bus #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, MEM = 2'd2, HALTED = 2'd3} state_t;

  state_t      state, state_next;
  logic [31:0] pc, npc, ir;
  logic [31:0] gpr [0:31];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt, wb_idx;
  logic [15:0] imm;
  logic [31:0] imm_s, imm_z, rs_val, rt_val, wb_val, target, ea;
  logic        wb_en, taken, is_lw, is_sw;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];
  assign imm    = ir[15:0];
  assign imm_s  = {{16{imm[15]}}, imm};
  assign imm_z  = {16'h0000, imm};
  // gpr[0] is never written, so it always reads back as zero
  assign rs_val = gpr[rs];
  assign rt_val = gpr[rt];
  assign ea     = rs_val + imm_s;

  assign register_v0 = gpr[2];
  assign byteenable  = 4'b1111;
  assign active      = (state != HALTED);

  always_comb begin
    wb_en  = 1'b0;
    wb_idx = rd;
    wb_val = 32'h0;
    taken  = 1'b0;
    target = 32'h0;
    is_lw  = 1'b0;
    is_sw  = 1'b0;
    case (opcode)
      6'h00: begin
        wb_en = 1'b1;
        case (funct)
          6'h00: wb_val = rt_val << shamt;
          6'h02: wb_val = rt_val >> shamt;
          6'h03: wb_val = $signed(rt_val) >>> shamt;
          6'h04: wb_val = rt_val << rs_val[4:0];
          6'h06: wb_val = rt_val >> rs_val[4:0];
          6'h07: wb_val = $signed(rt_val) >>> rs_val[4:0];
          6'h08: begin wb_en = 1'b0; taken = 1'b1; target = rs_val; end
          6'h09: begin taken = 1'b1; target = rs_val; wb_val = pc + 32'd8; end
          6'h21: wb_val = rs_val + rt_val;
          6'h23: wb_val = rs_val - rt_val;
          6'h24: wb_val = rs_val & rt_val;
          6'h25: wb_val = rs_val | rt_val;
          6'h26: wb_val = rs_val ^ rt_val;
          6'h27: wb_val = ~(rs_val | rt_val);
          6'h2A: wb_val = {31'b0, $signed(rs_val) < $signed(rt_val)};
          6'h2B: wb_val = {31'b0, rs_val < rt_val};
          default: wb_en = 1'b0;
        endcase
      end
      6'h02: begin taken = 1'b1; target = {npc[31:28], ir[25:0], 2'b00}; end
      6'h03: begin
        taken  = 1'b1;
        target = {npc[31:28], ir[25:0], 2'b00};
        wb_en  = 1'b1;
        wb_idx = 5'd31;
        wb_val = pc + 32'd8;
      end
      6'h04: begin taken = (rs_val == rt_val); target = npc + {imm_s[29:0], 2'b00}; end
      6'h05: begin taken = (rs_val != rt_val); target = npc + {imm_s[29:0], 2'b00}; end
      6'h09: begin wb_en = 1'b1; wb_idx = rt; wb_val = rs_val + imm_s; end
      6'h0A: begin wb_en = 1'b1; wb_idx = rt; wb_val = {31'b0, $signed(rs_val) < $signed(imm_s)}; end
      6'h0B: begin wb_en = 1'b1; wb_idx = rt; wb_val = {31'b0, rs_val < imm_s}; end
      6'h0C: begin wb_en = 1'b1; wb_idx = rt; wb_val = rs_val & imm_z; end
      6'h0D: begin wb_en = 1'b1; wb_idx = rt; wb_val = rs_val | imm_z; end
      6'h0E: begin wb_en = 1'b1; wb_idx = rt; wb_val = rs_val ^ imm_z; end
      6'h0F: begin wb_en = 1'b1; wb_idx = rt; wb_val = {imm, 16'h0000}; end
      6'h23: is_lw = 1'b1;
      6'h2B: is_sw = 1'b1;
      default: ;
    endcase
  end

  // Bus strobes are gated by reset so a pending request drops the instant reset rises
  always_comb begin
    state_next = state;
    read       = 1'b0;
    write      = 1'b0;
    address    = pc;
    writedata  = 32'h0;
    case (state)
      FETCH: begin
        read = !reset;
        if (!waitrequest) state_next = EXEC;
      end
      EXEC: begin
        if (is_lw || is_sw)  state_next = MEM;
        else if (npc == 0)   state_next = HALTED;
        else                 state_next = FETCH;
      end
      MEM: begin
        address   = ea & 32'hFFFF_FFFC;
        read      = is_lw && !reset;
        write     = is_sw && !reset;
        writedata = is_sw ? rt_val : 32'h0;
        if (!waitrequest) state_next = (npc == 0) ? HALTED : FETCH;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_VECTOR;
      npc   <= RESET_VECTOR + 32'd4;
      ir    <= 32'h0;
      for (int i = 0; i < 32; i++) gpr[i] <= 32'h0;
    end else begin
      state <= state_next;
      case (state)
        FETCH: if (!waitrequest) ir <= readdata;
        EXEC: if (!(is_lw || is_sw)) begin
          if (wb_en && wb_idx != 5'd0) gpr[wb_idx] <= wb_val;
          pc  <= npc;
          npc <= taken ? target : npc + 32'd4;
        end
        MEM: if (!waitrequest) begin
          if (is_lw && rt != 5'd0) gpr[rt] <= readdata;
          pc  <= npc;
          npc <= npc + 32'd4;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_bus.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mips_cpu_bus : directed programs on a 4096-word RAM with optional stalls |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_mips_cpu_bus;

  localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04, F_SRAV = 6'h07;
  localparam logic [5:0] F_JR = 6'h08, F_JALR = 6'h09, F_ADDU = 6'h21, F_SUBU = 6'h23;
  localparam logic [5:0] F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;

  logic        clk = 1'b0, reset = 1'b1, waitrequest, active, write, read;
  logic [31:0] register_v0, address, writedata, readdata;
  logic [3:0]  byteenable;

  logic [31:0] mem [0:4095];
  logic        stall_en = 1'b0;
  logic [2:0]  stall_cnt = 3'd0;
  int          checks = 0, errors = 0, pc_idx = 0;
  logic [31:0] last_waddr = 32'h0, last_wdata = 32'h0;
  logic        pend = 1'b0;
  logic [65:0] held = '0;

  mips_cpu_bus dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
    .address(address), .write(write), .read(read), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  always #5 clk = ~clk;

  // Boot ROM window 0xBFC0xxxx lives in the upper half; everything else in the lower half
  function automatic logic [11:0] ram_idx(input logic [31:0] a);
    return {a[31:16] == 16'hBFC0, a[12:2]};
  endfunction

  assign readdata    = mem[ram_idx(address)];
  assign waitrequest = stall_en && (stall_cnt != 3'd0);

  always @(posedge clk) begin
    if ((read || write) && waitrequest) stall_cnt <= stall_cnt - 3'd1;
    else if (read || write)             stall_cnt <= stall_en ? 3'($urandom_range(0, 5)) : 3'd0;
    if (write && !waitrequest) begin
      mem[ram_idx(address)] = writedata;
      last_waddr = address;
      last_wdata = writedata;
    end
    pend <= !reset && (read || write) && waitrequest;
    held <= {address, read, write, writedata};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (read || write)) begin
      chk("bus_byteenable", {28'h0, byteenable}, 32'hF);
      chk("bus_align", {30'h0, address[1:0]}, 32'h0);
      chk("bus_rw_exclusive", {31'h0, read && write}, 32'h0);
      if (pend) chk("bus_hold_stable", {31'h0, {address, read, write, writedata} !== held}, 32'h0);
    end
  end

  function automatic logic [31:0] rop(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, f};
  endfunction

  function automatic logic [31:0] iop(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic new_prog();
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    pc_idx = 0;
  endtask

  task automatic emit(input logic [31:0] w);
    mem[2048 + pc_idx] = w;
    pc_idx++;
  endtask

  task automatic emit_halt();
    emit(rop(F_JR, 5'd0, 5'd0, 5'd0, 5'd0));
    emit(32'h0);
  endtask

  task automatic run(input string tag, input logic [31:0] exp);
    reset = 1'b1;
    @(posedge clk); #1;
    chk({tag, ":rst_rw"}, {30'h0, read, write}, 32'h0);
    chk({tag, ":rst_active"}, {31'h0, active}, 32'h1);
    @(negedge clk); reset = 1'b0;
    #1 chk({tag, ":first_fetch"}, address, 32'hBFC0_0000);
    for (int c = 0; c < 4000 && active; c++) @(posedge clk);
    #1 chk({tag, ":halted"}, {31'h0, active}, 32'h0);
    chk({tag, ":v0"}, register_v0, exp);
    repeat (3) @(posedge clk);
    #1 chk({tag, ":halt_sticky"}, {29'h0, active, read, write}, 32'h0);
  endtask

  initial begin
    #1;
    chk("reset_rw", {30'h0, read, write}, 32'h0);
    chk("reset_wdata", writedata, 32'h0);
    chk("reset_v0", register_v0, 32'h0);
    chk("reset_active", {31'h0, active}, 32'h1);

    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk); stall_en = (pass == 1);

      new_prog();  // LW, JR $0 with ORI in its delay slot
      emit(iop(OP_LW, 5'd0, 5'd3, 16'h0004));
      emit(rop(F_JR, 5'd0, 5'd0, 5'd0, 5'd0));
      emit(iop(OP_ORI, 5'd3, 5'd2, 16'hFFFF));
      mem[1] = 32'hBABA_0000;
      run("t1_lw_ori", 32'hBABA_FFFF);

      new_prog();
      emit(iop(OP_ADDIU, 5'd0, 5'd2, 16'hFFFF));
      emit(iop(OP_ADDIU, 5'd2, 5'd2, 16'h0002));
      emit_halt();
      run("t2_addiu_wrap", 32'h1);

      new_prog();
      emit(iop(OP_LUI, 5'd0, 5'd2, 16'h1234));
      emit(iop(OP_ORI, 5'd2, 5'd2, 16'h5678));
      emit_halt();
      run("t2_lui_ori", 32'h1234_5678);

      new_prog();
      emit(iop(OP_LUI, 5'd0, 5'd4, 16'hDEAD));
      emit(iop(OP_ORI, 5'd4, 5'd4, 16'hBEEF));
      emit(iop(OP_SW, 5'd0, 5'd4, 16'h0100));
      emit(iop(OP_LW, 5'd0, 5'd2, 16'h0100));
      emit_halt();
      run("t3_sw_lw", 32'hDEAD_BEEF);
      chk("t3_waddr", last_waddr, 32'h0000_0100);
      chk("t3_wdata", last_wdata, 32'hDEAD_BEEF);
      chk("t3_ram", mem[64], 32'hDEAD_BEEF);

      new_prog();  // BEQ taken over one ADDIU, then BNE not taken
      emit(iop(OP_ADDIU, 5'd0, 5'd2, 16'h0000));
      emit(iop(OP_BEQ, 5'd0, 5'd0, 16'h0002));
      emit(iop(OP_ADDIU, 5'd2, 5'd2, 16'h0001));
      emit(iop(OP_ADDIU, 5'd2, 5'd2, 16'h0010));
      emit(iop(OP_BNE, 5'd2, 5'd2, 16'h0004));
      emit(iop(OP_ADDIU, 5'd0, 5'd5, 16'h0005));
      emit(iop(OP_ADDIU, 5'd2, 5'd2, 16'h0020));
      emit_halt();
      emit(iop(OP_ADDIU, 5'd2, 5'd2, 16'h0040));
      emit_halt();
      run("t4_branches", 32'h21);

      for (int v = 0; v < 2; v++) begin  // JAL 0xBFC00010, subroutine, JR $31
        new_prog();
        emit({OP_JAL, 26'h3F0_0004});
        emit(32'h0);
        emit_halt();
        if (v == 0) emit(iop(OP_ADDIU, 5'd0, 5'd2, 16'h0007));
        else        emit(rop(F_ADDU, 5'd31, 5'd0, 5'd2, 5'd0));
        emit(rop(F_JR, 5'd31, 5'd0, 5'd0, 5'd0));
        emit(32'h0);
        if (v == 0) run("t5_jal_v0", 32'h7);
        else        run("t5_jal_link", 32'hBFC0_0008);
      end

      new_prog();  // JALR $9,$8 to 0xBFC00018; link is 0xBFC00010
      emit(iop(OP_LUI, 5'd0, 5'd8, 16'hBFC0));
      emit(iop(OP_ORI, 5'd8, 5'd8, 16'h0018));
      emit(rop(F_JALR, 5'd8, 5'd0, 5'd9, 5'd0));
      emit(32'h0);
      emit_halt();
      emit(rop(F_ADDU, 5'd9, 5'd0, 5'd2, 5'd0));
      emit(rop(F_JR, 5'd9, 5'd0, 5'd0, 5'd0));
      emit(32'h0);
      run("t7_jalr", 32'hBFC0_0010);

      new_prog();
      emit(iop(OP_LUI, 5'd0, 5'd3, 16'h8000));
      emit(rop(F_SRA, 5'd0, 5'd3, 5'd5, 5'd4));
      emit(rop(F_SRL, 5'd0, 5'd3, 5'd6, 5'd4));
      emit(rop(F_XOR, 5'd5, 5'd6, 5'd2, 5'd0));
      emit_halt();
      run("t8_shifts", 32'hF000_0000);

      new_prog();
      emit(iop(OP_ADDIU, 5'd0, 5'd3, 16'hFFFF));
      emit(rop(F_SLT, 5'd3, 5'd0, 5'd4, 5'd0));
      emit(rop(F_SLTU, 5'd0, 5'd3, 5'd5, 5'd0));
      emit(rop(F_SLL, 5'd0, 5'd4, 5'd4, 5'd1));
      emit(rop(F_OR, 5'd4, 5'd5, 5'd2, 5'd0));
      emit_halt();
      run("t9_slt", 32'h3);

      new_prog();
      emit(iop(OP_ADDIU, 5'd0, 5'd3, 16'h0F0F));
      emit(iop(OP_XORI, 5'd3, 5'd4, 16'h00FF));
      emit(rop(F_NOR, 5'd4, 5'd0, 5'd5, 5'd0));
      emit(iop(OP_ANDI, 5'd5, 5'd6, 16'h8F0F));
      emit(rop(F_SUBU, 5'd6, 5'd3, 5'd2, 5'd0));
      emit_halt();
      run("t10_logic", 32'h0000_7100);

      new_prog();
      emit(iop(OP_ADDIU, 5'd0, 5'd3, 16'h0004));
      emit(iop(OP_ADDIU, 5'd0, 5'd4, 16'hFFF0));
      emit(rop(F_SRAV, 5'd3, 5'd4, 5'd5, 5'd0));
      emit(iop(OP_SLTIU, 5'd3, 5'd6, 16'hFFFF));
      emit(iop(OP_SLTI, 5'd4, 5'd7, 16'hFFF1));
      emit(rop(F_SLLV, 5'd3, 5'd6, 5'd2, 5'd0));
      emit(rop(F_ADDU, 5'd2, 5'd7, 5'd2, 5'd0));
      emit(rop(F_ADDU, 5'd2, 5'd5, 5'd2, 5'd0));
      emit_halt();
      run("t11_var_shift", 32'h10);

      new_prog();  // J over a poisoning ADDIU
      emit(iop(OP_ADDIU, 5'd0, 5'd2, 16'h0003));
      emit({OP_J, 26'h3F0_0004});
      emit(32'h0);
      emit(iop(OP_ADDIU, 5'd0, 5'd2, 16'h0099));
      emit_halt();
      run("t12_j", 32'h3);
    end

    // Reset in the middle of the store/load program, with stalls on
    new_prog();
    emit(iop(OP_LUI, 5'd0, 5'd4, 16'hDEAD));
    emit(iop(OP_ORI, 5'd4, 5'd4, 16'hBEEF));
    emit(iop(OP_SW, 5'd0, 5'd4, 16'h0100));
    emit(iop(OP_LW, 5'd0, 5'd2, 16'h0100));
    emit_halt();
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("midrst_rw_drop", {30'h0, read, write}, 32'h0);
    chk("midrst_v0_clear", register_v0, 32'h0);
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1 chk("midrst_refetch_addr", address, 32'hBFC0_0000);
    chk("midrst_refetch_read", {31'h0, read}, 32'h1);
    for (int c = 0; c < 4000 && active; c++) @(posedge clk);
    #1 chk("midrst_halted", {31'h0, active}, 32'h0);
    chk("midrst_v0", register_v0, 32'hDEAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
